noc_local_packetizer: RTL and testbench
=======================================

// Module: noc_local_packetizer
// PURPOSE
//  Network-interface injector. Sits upstream of the fabric local receiver port of one node.
//  Takes a message (destination + 0..MAX_LEN payload words) and emits a wormhole packet of
//  HEAD/BODY/TAIL flits on the local flit channel. Claims one VC per packet.
// PARAMETERS
//  PAYLOAD_W  32  payload bits per flit
//  MAX_LEN    8   max payload words per message; LEN_W = $clog2(MAX_LEN+1)
//  VC_NUM     2   virtual channels on the local port; VC_W = max(1,$clog2(VC_NUM))
// PORTS
//  noc_clk      in   1          NoC clock
//  noc_rst      in   1          asynchronous, active-high reset
//  id_x / id_y  in   Noc_ID_X_Width / Noc_ID_Y_Width   own node id, placed in head flit
//  msg_valid    in   1          message header offered
//  msg_ready    out  1          header accepted when msg_valid&&msg_ready
//  msg_dst_x    in   Noc_ID_X_Width   destination x
//  msg_dst_y    in   Noc_ID_Y_Width   destination y
//  msg_len      in   LEN_W      payload word count, 0..MAX_LEN
//  word_valid   in   1          payload word offered
//  word_ready   out  1          word accepted when word_valid&&word_ready
//  word_data    in   PAYLOAD_W  payload word
//  flit_valid   out  1          flit on channel
//  flit_ready   in   1          flit transfer = flit_valid&&flit_ready
//  flit_vc_ready in  VC_NUM     per-VC downstream buffer space
//  flit_data    out  2+VC_W+PAYLOAD_W  {type[1:0], vc, payload}
//  busy         out  1          packet in progress (state!=IDLE or flit_valid)
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE. flit_valid, msg_ready, word_ready and busy are 0.
//    flit_data is 0. VC round-robin pointer is 0. A partial packet is dropped.
//  - Flit types: 2'b00 HEAD, 2'b01 BODY, 2'b10 TAIL, 2'b11 HEADTAIL (msg_len==0).
//  - Head payload (LSB first): src_x, src_y, dst_x, dst_y, len, seq[7:0]. Upper bits are 0.
//  - The output register holds exactly one flit. It is loadable when !flit_valid || transfer.
//  - FSM states IDLE, BODY:
//    IDLE: msg_ready = loadable && |flit_vc_ready.
//      On acceptance:
//        * Pick the VC round-robin among the ready bits, starting after the last used VC.
//        * Load the HEAD flit, or HEADTAIL if len==0.
//        * Set rem=len and lock the VC.
//        * Go to BODY if len>0, else stay in IDLE.
//      Head flit_valid rises the cycle after acceptance (1-cycle latency).
//    BODY: word_ready = loadable && flit_vc_ready[locked_vc].
//      On each accepted word:
//        * Load a BODY flit, or TAIL if rem==1.
//        * rem--.
//        * rem==1 -> return to IDLE.
//  - Flit_valid stays high and flit_data stable until transfer. Back-to-back transfers give 1 flit/cycle.
//  - Simultaneous transfer + load in the same cycle is legal: the new flit replaces the old one, no bubble.
//  - flit_vc_ready falling while a flit is held does not drop flit_valid. It only gates new loads.
//  - Words offered in IDLE are not accepted (word_ready=0). Headers offered in BODY wait (msg_ready=0).
//  - msg_len>MAX_LEN is clamped to MAX_LEN.
//  - All flits of a packet carry the same VC. The VC pointer advances only on header acceptance.
// CONFIGURATION
//  NOC_PKT_SEQ_EN defined: an 8-bit sequence counter goes into the head seq field.
//    It increments on every header acceptance and wraps 255->0.
//  Not defined: the seq field is constant 0 and there is no counter flop.
// STRUCTURE
//  Noc_parameters package gets:
//    * Noc_flit_type_e enum
//    * Noc_head_payload_t packed struct
//    * PAYLOAD_W / MAX_LEN / VC_NUM defaults
//  Sub-module noc_vc_rr_picker:
//    * inputs: ready vector, pointer
//    * outputs: one-hot grant, encoded vc
//    * pointer update on an enable pulse
// TESTING
//  1. len=3, dst=(2,1), all vc_ready=1, flit_ready=1
//     -> HEAD,BODY,BODY,TAIL on consecutive cycles, vc=0; next packet uses vc=1.
//  2. len=0 -> single HEADTAIL flit. msg_ready is high again the cycle after the transfer.
//  3. flit_ready=0 for 5 cycles mid-packet
//     -> flit_data stable, word_ready=0, no word lost or duplicated.
//  4. flit_vc_ready=2'b10 at the header -> packet on vc=1.
//     Drop vc_ready[1] mid-body -> stall; restore it -> resume.
//  5. noc_rst asserted after the 2nd flit of a len=5 packet
//     -> flit_valid=0 immediately; the next message starts with a HEAD on vc=0.
//  6. With NOC_PKT_SEQ_EN: send 257 packets -> seq values 0..255, then 0.
//     Without the macro -> seq is always 0.

Source files
------------

// File: rtl/noc_local_packetizer_pkg.sv
// Shared types and defaults for the local-port packetizer: flit type codes,
// head-flit payload layout and the default channel dimensions.
package noc_local_packetizer_pkg;

    localparam int Noc_ID_X_Width = 4;
    localparam int Noc_ID_Y_Width = 4;

    localparam int NOC_PAYLOAD_W = 32;
    localparam int NOC_MAX_LEN   = 8;
    localparam int NOC_VC_NUM    = 2;
    localparam int NOC_LEN_W     = $clog2(NOC_MAX_LEN + 1);
    localparam int NOC_SEQ_W     = 8;

    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'b00,
        FLIT_BODY     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } Noc_flit_type_e;

    // Declared MSB first so src_x lands in the least significant bits.
    typedef struct packed {
        logic [NOC_SEQ_W-1:0]      seq;
        logic [NOC_LEN_W-1:0]      len;
        logic [Noc_ID_Y_Width-1:0] dst_y;
        logic [Noc_ID_X_Width-1:0] dst_x;
        logic [Noc_ID_Y_Width-1:0] src_y;
        logic [Noc_ID_X_Width-1:0] src_x;
    } Noc_head_payload_t;

    function automatic int vc_width(input int vc_num);
        return (vc_num > 1) ? $clog2(vc_num) : 1;
    endfunction

endpackage

// File: rtl/noc_local_packetizer_if.sv
// Message, payload-word and flit channels of the local packetizer.
// master = packetizer side, slave = message source / fabric side.
interface noc_local_packetizer_if
    import noc_local_packetizer_pkg::*;
#(
    parameter int PAYLOAD_W = NOC_PAYLOAD_W,
    parameter int MAX_LEN   = NOC_MAX_LEN,
    parameter int VC_NUM    = NOC_VC_NUM
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int VC_W   = vc_width(VC_NUM);
    localparam int FLIT_W = 2 + VC_W + PAYLOAD_W;

    logic                      msg_valid;
    logic                      msg_ready;
    logic [Noc_ID_X_Width-1:0] msg_dst_x;
    logic [Noc_ID_Y_Width-1:0] msg_dst_y;
    logic [LEN_W-1:0]          msg_len;

    logic                      word_valid;
    logic                      word_ready;
    logic [PAYLOAD_W-1:0]      word_data;

    logic                      flit_valid;
    logic                      flit_ready;
    logic [VC_NUM-1:0]         flit_vc_ready;
    logic [FLIT_W-1:0]         flit_data;

    modport master (
        input  msg_valid, msg_dst_x, msg_dst_y, msg_len,
        input  word_valid, word_data,
        input  flit_ready, flit_vc_ready,
        output msg_ready, word_ready, flit_valid, flit_data
    );

    modport slave (
        output msg_valid, msg_dst_x, msg_dst_y, msg_len,
        output word_valid, word_data,
        output flit_ready, flit_vc_ready,
        input  msg_ready, word_ready, flit_valid, flit_data
    );

endinterface

// File: rtl/noc_local_packetizer_vc_rr.sv
// Round-robin VC picker: grants the first ready VC at or after the pointer,
// and moves the pointer past the granted VC when en pulses.
module noc_vc_rr_picker
    import noc_local_packetizer_pkg::*;
#(
    parameter  int VC_NUM = NOC_VC_NUM,
    localparam int VC_W   = vc_width(VC_NUM)
) (
    input  logic              noc_clk,
    input  logic              noc_rst,
    input  logic [VC_NUM-1:0] ready,
    input  logic              en,
    output logic [VC_NUM-1:0] grant,
    output logic [VC_W-1:0]   vc
);

    logic [VC_W-1:0] ptr;
    logic            found;
    int              idx;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        grant = '0;
        vc    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = (int'(ptr) + i) % VC_NUM;
            if (!found && ready[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                vc         = VC_W'(idx);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (vc == VC_W'(VC_NUM - 1)) ? '0 : vc + 1'b1;
        end
    end

endmodule

// File: rtl/noc_local_packetizer.sv
// Local-port injector: turns a message into a HEAD/BODY/TAIL wormhole packet on one VC.
// Optional NOC_PKT_SEQ_EN adds an 8-bit per-header sequence number in the head flit.
module noc_local_packetizer
    import noc_local_packetizer_pkg::*;
#(
    parameter int PAYLOAD_W = NOC_PAYLOAD_W,
    parameter int MAX_LEN   = NOC_MAX_LEN,
    parameter int VC_NUM    = NOC_VC_NUM
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic [Noc_ID_X_Width-1:0] id_x,
    input  logic [Noc_ID_Y_Width-1:0] id_y,
    noc_local_packetizer_if.master    pif,
    output logic                      busy
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int VC_W   = vc_width(VC_NUM);
    localparam int FLIT_W = 2 + VC_W + PAYLOAD_W;

    typedef enum logic {
        ST_IDLE,
        ST_BODY
    } state_e;

    state_e              state;
    logic [LEN_W-1:0]    rem;
    logic [VC_W-1:0]     locked_vc;
    logic                flit_valid_q;
    logic [FLIT_W-1:0]   flit_data_q;
    logic [NOC_SEQ_W-1:0] seq;

    logic                transfer;
    logic                loadable;
    logic                msg_hs;
    logic                word_hs;
    logic [LEN_W-1:0]    len_c;
    logic [VC_NUM-1:0]   pick_grant;
    logic [VC_W-1:0]     pick_vc;
    Noc_head_payload_t   head;
    Noc_flit_type_e      head_type;
    Noc_flit_type_e      body_type;

    assign transfer = flit_valid_q && pif.flit_ready;
    assign loadable = !flit_valid_q || transfer;

    // Handshake readies are gated by reset so nothing looks acceptable while it is held.
    assign pif.msg_ready  = !noc_rst && (state == ST_IDLE) && loadable && |pick_grant;
    assign pif.word_ready = !noc_rst && (state == ST_BODY) && loadable && pif.flit_vc_ready[locked_vc];

    assign msg_hs  = pif.msg_valid  && pif.msg_ready;
    assign word_hs = pif.word_valid && pif.word_ready;

    assign len_c = (pif.msg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pif.msg_len;

    assign pif.flit_valid = flit_valid_q;
    assign pif.flit_data  = flit_data_q;
    assign busy           = (state != ST_IDLE) || flit_valid_q;

    noc_vc_rr_picker #(
        .VC_NUM (VC_NUM)
    ) u_vc_picker (
        .noc_clk (noc_clk),
        .noc_rst (noc_rst),
        .ready   (pif.flit_vc_ready),
        .en      (msg_hs),
        .grant   (pick_grant),
        .vc      (pick_vc)
    );

`ifdef NOC_PKT_SEQ_EN
    logic [NOC_SEQ_W-1:0] seq_q;

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            seq_q <= '0;
        end else if (msg_hs) begin
            seq_q <= seq_q + 1'b1;
        end
    end

    assign seq = seq_q;
`else
    assign seq = '0;
`endif

    always_comb begin
        head       = '0;
        head.src_x = id_x;
        head.src_y = id_y;
        head.dst_x = pif.msg_dst_x;
        head.dst_y = pif.msg_dst_y;
        head.len   = NOC_LEN_W'(len_c);
        head.seq   = seq;
        head_type  = (len_c == '0) ? FLIT_HEADTAIL : FLIT_HEAD;
        body_type  = (rem == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
    end

    // A load in the same cycle as a transfer overrides the clear, so there is no bubble.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state        <= ST_IDLE;
            rem          <= '0;
            locked_vc    <= '0;
            flit_valid_q <= 1'b0;
            flit_data_q  <= '0;
        end else begin
            if (transfer) begin
                flit_valid_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (msg_hs) begin
                        flit_valid_q <= 1'b1;
                        flit_data_q  <= {head_type, pick_vc, PAYLOAD_W'(head)};
                        rem          <= len_c;
                        locked_vc    <= pick_vc;
                        if (len_c != '0) begin
                            state <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (word_hs) begin
                        flit_valid_q <= 1'b1;
                        flit_data_q  <= {body_type, locked_vc, pif.word_data};
                        rem          <= rem - 1'b1;
                        if (rem == LEN_W'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_local_packetizer.sv
// Scoreboard bench for noc_local_packetizer: drivers push expected flits,
// a monitor pops and compares on every flit transfer.
module tb_noc_local_packetizer;
    import noc_local_packetizer_pkg::*;

    localparam int PAYLOAD_W = 32;
    localparam int MAX_LEN   = 8;
    localparam int VC_NUM    = 2;
    localparam int LEN_W     = $clog2(MAX_LEN + 1);
    localparam int VC_W      = 1;
    localparam int FLIT_W    = 2 + VC_W + PAYLOAD_W;
    localparam int ID_X      = 3;
    localparam int ID_Y      = 5;
    localparam int HS_LIMIT  = 200;

    logic noc_clk = 1'b0;
    logic noc_rst = 1'b1;
    logic busy;

    noc_local_packetizer_if #(.PAYLOAD_W(PAYLOAD_W), .MAX_LEN(MAX_LEN), .VC_NUM(VC_NUM)) pif ();

    noc_local_packetizer #(
        .PAYLOAD_W (PAYLOAD_W),
        .MAX_LEN   (MAX_LEN),
        .VC_NUM    (VC_NUM)
    ) dut (
        .noc_clk (noc_clk),
        .noc_rst (noc_rst),
        .id_x    (4'(ID_X)),
        .id_y    (4'(ID_Y)),
        .pif     (pif),
        .busy    (busy)
    );

    always #5 noc_clk = ~noc_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int last_cyc = -10;
    int run = 0;
    int max_run = 0;
    int seq_cnt = 0;
    bit abort = 1'b0;
    logic [FLIT_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk_flit(input Noc_flit_type_e t, input logic [VC_W-1:0] vc,
                                                  input logic [31:0] p);
        return {t, vc, p};
    endfunction

    function automatic logic [31:0] head_word(input int dx, input int dy, input int len, input int s);
        return (32'(s) << 20) | (32'(len) << 16) | (32'(dy) << 12) | (32'(dx) << 8) |
               (32'(ID_Y) << 4) | 32'(ID_X);
    endfunction

    initial forever begin
        @(posedge noc_clk);
        cyc++;
    end

    // Monitor: one comparison per flit transfer.
    initial forever begin
        logic [FLIT_W-1:0] exp;
        @(negedge noc_clk);
        if (!noc_rst && pif.flit_valid && pif.flit_ready) begin
            run      = (cyc == last_cyc + 1) ? run + 1 : 1;
            last_cyc = cyc;
            if (run > max_run) max_run = run;
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flit actual=%h expected=none", pif.flit_data);
            end else begin
                exp = exp_q.pop_front();
                check("flit", 64'(pif.flit_data), 64'(exp));
            end
        end
    end

    task automatic wait_hs(input bit is_msg, output bit ok);
        int t;
        t  = 0;
        ok = 1'b0;
        forever begin
            @(negedge noc_clk);
            if (abort) break;
            if (is_msg ? pif.msg_ready : pif.word_ready) begin
                ok = 1'b1;
                break;
            end
            t++;
            if (t > HS_LIMIT) begin
                checks++;
                errors++;
                $display("FAIL hs_timeout actual=no_ready expected=ready is_msg=%0d", is_msg);
                break;
            end
        end
        @(posedge noc_clk);
        #1;
    endtask

    task automatic send_pkt(input int dx, input int dy, input int len_req, input int vc,
                            input logic [31:0] base);
        int n;
        int s;
        bit ok;
        n = (len_req > MAX_LEN) ? MAX_LEN : len_req;
`ifdef NOC_PKT_SEQ_EN
        s = seq_cnt;
`else
        s = 0;
`endif
        seq_cnt = (seq_cnt + 1) % 256;
        exp_q.push_back(mk_flit((n == 0) ? FLIT_HEADTAIL : FLIT_HEAD, VC_W'(vc), head_word(dx, dy, n, s)));
        for (int i = 0; i < n; i++)
            exp_q.push_back(mk_flit((i == n - 1) ? FLIT_TAIL : FLIT_BODY, VC_W'(vc), base + 32'(i)));
        pif.msg_dst_x = 4'(dx);
        pif.msg_dst_y = 4'(dy);
        pif.msg_len   = LEN_W'(len_req);
        pif.msg_valid = 1'b1;
        wait_hs(1'b1, ok);
        pif.msg_valid = 1'b0;
        for (int i = 0; i < n && ok; i++) begin
            pif.word_data  = base + 32'(i);
            pif.word_valid = 1'b1;
            wait_hs(1'b0, ok);
            pif.word_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < HS_LIMIT) begin
            @(negedge noc_clk);
            t++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge noc_clk);
        #1;
    endtask

    task automatic wait_xfers(input int target);
        int t;
        t = 0;
        while (xfer_cnt < target && t < HS_LIMIT) begin
            @(posedge noc_clk);
            #1;
            t++;
        end
        check("xfer_wait", 64'(xfer_cnt >= target), 64'd1);
    endtask

    task automatic apply_reset();
        @(posedge noc_clk);
        #1;
        noc_rst = 1'b1;
        exp_q.delete();
        seq_cnt = 0;
        repeat (2) @(posedge noc_clk);
        #1;
        noc_rst = 1'b0;
    endtask

    task automatic stall_flit();
        logic [FLIT_W-1:0] held;
        wait_xfers(xfer_cnt + 2);
        pif.flit_ready = 1'b0;
        @(negedge noc_clk);
        held = pif.flit_data;
        check("stall_valid", 64'(pif.flit_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_data", 64'(pif.flit_data), 64'(held));
            check("stall_word_ready", 64'(pif.word_ready), 64'd0);
            check("body_msg_ready", 64'(pif.msg_ready), 64'd0);
            if (i < 4) @(negedge noc_clk);
        end
        @(posedge noc_clk);
        #1;
        pif.flit_ready = 1'b1;
    endtask

    task automatic stall_vc();
        wait_xfers(xfer_cnt + 2);
        pif.flit_vc_ready = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge noc_clk);
            check("vc_stall_word_ready", 64'(pif.word_ready), 64'd0);
        end
        check("vc_stall_drained", 64'(pif.flit_valid), 64'd0);
        check("vc_stall_busy", 64'(busy), 64'd1);
        @(posedge noc_clk);
        #1;
        pif.flit_vc_ready = 2'b11;
    endtask

    task automatic reset_mid();
        wait_xfers(xfer_cnt + 2);
        noc_rst = 1'b1;
        abort   = 1'b1;
        #1;
        check("rst_flit_valid", 64'(pif.flit_valid), 64'd0);
        check("rst_flit_data", 64'(pif.flit_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_msg_ready", 64'(pif.msg_ready), 64'd0);
        check("rst_word_ready", 64'(pif.word_ready), 64'd0);
        exp_q.delete();
        seq_cnt = 0;
        repeat (2) @(posedge noc_clk);
        #1;
        noc_rst = 1'b0;
    endtask

    initial begin
        pif.msg_valid     = 1'b0;
        pif.msg_dst_x     = '0;
        pif.msg_dst_y     = '0;
        pif.msg_len       = '0;
        pif.word_valid    = 1'b0;
        pif.word_data     = '0;
        pif.flit_ready    = 1'b1;
        pif.flit_vc_ready = 2'b11;

        repeat (2) @(negedge noc_clk);
        check("reset_flit_valid", 64'(pif.flit_valid), 64'd0);
        check("reset_flit_data", 64'(pif.flit_data), 64'd0);
        check("reset_msg_ready", 64'(pif.msg_ready), 64'd0);
        check("reset_word_ready", 64'(pif.word_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(posedge noc_clk);
        #1;
        noc_rst = 1'b0;

        // Words offered while idle are ignored.
        pif.word_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge noc_clk);
            check("idle_word_ready", 64'(pif.word_ready), 64'd0);
            check("idle_msg_ready", 64'(pif.msg_ready), 64'd1);
        end
        @(posedge noc_clk);
        #1;
        pif.word_valid = 1'b0;

        // 1: len=3 to (2,1) on vc0, next packet on vc1, all back to back.
        max_run = 0;
        send_pkt(2, 1, 3, 0, 32'hA000_0000);
        send_pkt(4, 6, 1, 1, 32'hB000_0000);
        drain();
        check("t1_back_to_back", 64'(max_run), 64'd6);

        // 2: len=0 -> single HEADTAIL; ready again right after the transfer.
        send_pkt(7, 2, 0, 0, 32'h0);
        @(negedge noc_clk);
        check("t2_head_latency", 64'(pif.flit_valid), 64'd1);
        @(negedge noc_clk);
        check("t2_msg_ready_after", 64'(pif.msg_ready), 64'd1);
        check("t2_valid_after", 64'(pif.flit_valid), 64'd0);
        check("t2_busy_after", 64'(busy), 64'd0);
        drain();

        // 3: flit_ready low for 5 cycles mid-packet.
        fork
            send_pkt(1, 3, 4, 1, 32'hC000_0000);
            stall_flit();
        join
        drain();

        // 4: only vc1 ready at the header, then vc1 drops mid-body.
        pif.flit_vc_ready = 2'b10;
        fork
            send_pkt(5, 5, 3, 1, 32'hD000_0000);
            stall_vc();
        join
        drain();

        // 5: reset after the 2nd flit of a len=5 packet; next starts on vc0.
        fork
            send_pkt(6, 0, 5, 0, 32'hE000_0000);
            reset_mid();
        join
        abort = 1'b0;
        send_pkt(3, 3, 1, 0, 32'hF000_0000);
        drain();

        // Oversized length is clamped to MAX_LEN.
        send_pkt(9, 8, 12, 1, 32'h1234_0000);
        drain();

        // 6: 257 header-only packets, seq wraps 255 -> 0 when enabled.
        apply_reset();
        for (int i = 0; i < 257; i++)
            send_pkt(i % 16, (i / 16) % 16, 0, i % 2, 32'h0);
        drain();
        check("final_idle_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
